// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between IF and mem_ctrl.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache #(
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic        mc_enable,
    output logic [31:0] mc_addr,
    input  logic [31:0] mc_inst,
    input  logic        mc_finished
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StMiss, StDrain} state_e;

    state_e state_q, state_d;

    logic [31:0]           data_q  [Lines];
    logic [TAG_BITS-1:0]   tag_q   [Lines];
    logic [Lines-1:0]      valid_q;

    logic [31:0]           word_addr;
    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  req_io, fill_io;
    logic                  accept, lookup_hit, fill_we;

    logic                  if_valid_d, mc_enable_d;
    logic [31:0]           if_inst_d, mc_addr_d;

    assign word_addr  = if_addr & ~32'h3;
    assign req_idx    = word_addr[2+INDEX_BITS-1:2];
    assign req_tag    = word_addr[17:2+INDEX_BITS];
    assign req_io     = (word_addr[17:16] == 2'b11);
    // The outstanding miss address lives in mc_addr, so fill index/tag come from it.
    assign fill_idx   = mc_addr[2+INDEX_BITS-1:2];
    assign fill_tag   = mc_addr[17:2+INDEX_BITS];
    assign fill_io    = (mc_addr[17:16] == 2'b11);

    // The cycle showing if_valid still sees the old request held, so it is skipped.
    assign accept     = (state_q == StIdle) && if_req && !if_abort && !if_valid;
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !req_io;

    always_comb begin
        state_d     = state_q;
        if_valid_d  = 1'b0;
        if_inst_d   = if_inst;
        mc_enable_d = mc_enable;
        mc_addr_d   = mc_addr;
        fill_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (lookup_hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_q[req_idx];
                    end else begin
                        mc_addr_d   = word_addr;
                        mc_enable_d = 1'b1;
                        state_d     = StMiss;
                    end
                end
            end
            StMiss: begin
                if (mc_finished) begin
                    mc_enable_d = 1'b0;
                    fill_we     = !fill_io;
                    state_d     = StIdle;
                    if (!if_abort) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = mc_inst;
                    end
                end else if (if_abort) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mc_finished) begin
                    mc_enable_d = 1'b0;
                    fill_we     = !fill_io;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            mc_enable <= 1'b0;
            mc_addr   <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            if_valid  <= if_valid_d;
            if_inst   <= if_inst_d;
            mc_enable <= mc_enable_d;
            mc_addr   <= mc_addr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            data_q[fill_idx] <= mc_inst;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy && accept) begin
            if (lookup_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the IF stage and mem_ctrl.
- It serves instruction fetches from an internal array and sends misses to mem_ctrl's IF port.
- It fills the missing line from the returned word.
- With it, straight-line loops run without the 4-byte serial RAM fetch on every instruction.

Parameters:
- INDEX_BITS, 7: line index width; 2^INDEX_BITS lines, one 32-bit word per line.
- TAG_BITS, 16-INDEX_BITS: tag width, taken from addr[17:2+INDEX_BITS].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global ready; when low all state is frozen
- if_req  in  1  fetch request from IF; held until if_valid or if_abort
- if_addr  in  32  fetch PC; stable while if_req high; bits [1:0] ignored
- if_abort  in  1  branch/jump flush; cancels the outstanding request
- if_valid  out  1  one-cycle pulse: if_inst valid for the current request
- if_inst  out  32  instruction word
- mc_enable  out  1  fetch request to mem_ctrl; held until mc_finished
- mc_addr  out  32  word-aligned fetch address to mem_ctrl
- mc_inst  in  32  word returned by mem_ctrl
- mc_finished  in  1  one-cycle pulse: mc_inst valid

Behaviour:
- Reset, asynchronous:
  - All valid bits cleared.
  - State IDLE.
  - if_valid=0, if_inst=0, mc_enable=0, mc_addr=0.
  - Data and tag arrays are not reset.
- rdy=0: no state, array or output-register change. Inputs are ignored that cycle.
- Address split: index=addr[2+INDEX_BITS-1:2], tag=addr[17:2+INDEX_BITS]. Bits [31:18] are not compared.
- IO bypass: addr[17:16]==2'b11 is always treated as a miss. It is fetched via mem_ctrl and never written into the array.
- State IDLE:
  - if_req=1, not aborted, and (valid[index] and tag match): hit. Next cycle if_valid=1, if_inst=array word. Stay IDLE. Hit latency is exactly 1 cycle.
  - if_req=1 and miss: latch address, mc_addr={if_addr[31:2],2'b00}, mc_enable=1, go to MISS.
- State MISS:
  - mc_enable stays high until mc_finished.
  - On mc_finished: mc_enable=0 the same edge.
  - Write mc_inst, tag and valid=1 into the line unless IO bypass.
  - Next cycle if_valid=1, if_inst=mc_inst. Return to IDLE.
- State DRAIN:
  - Entered from MISS when if_abort=1 before mc_finished.
  - mc_enable stays high; mem_ctrl transactions are not cancellable.
  - On mc_finished: fill the line as normal, drop mc_enable, no if_valid pulse. Go to IDLE.
  - if_req received in DRAIN is not accepted until IDLE.
- if_abort in IDLE: the same-cycle request is dropped, no if_valid. if_abort has priority over a hit.
- if_abort coincident with mc_finished in MISS: the fill completes and if_valid is suppressed.
- if_valid is never asserted in two consecutive cycles for one request. IF must deassert or change if_req/if_addr after if_valid.
- Back-to-back hits: a new request may be sampled the cycle after if_valid, giving a throughput of one fetch per 2 cycles.
- Fill-then-hit on the same line in the next request returns the filled word. Array write is visible the following cycle.
- No self-modifying-code coherence: stores do not invalidate lines.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Reset to 0; frozen when rdy=0.
  - hit_cnt increments on each accepted hit.
  - miss_cnt increments on each transition IDLE->MISS, IO bypass included.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, if_req with if_addr=0x00000100; mem_ctrl returns 0x00500093 after 5 cycles.
  - Required response: mc_enable high 5 cycles with mc_addr=0x100, then if_valid with if_inst=0x00500093.
- Hit after fill:
  - Stimulus: re-request 0x100.
  - Required response: if_valid exactly 1 cycle after request, if_inst=0x00500093, mc_enable stays 0.
- Conflict eviction:
  - Stimulus: fill 0x100, then 0x300 (same index for INDEX_BITS=7), then 0x100 again.
  - Required response: three misses, each with the correct word returned.
- Abort mid-miss:
  - Stimulus: request 0x200, assert if_abort 2 cycles later, then complete mc_finished.
  - Required response: no if_valid; a subsequent request to 0x200 hits in 1 cycle.
- IO bypass and rdy freeze:
  - Stimulus: request 0x30000 twice.
  - Required response: both requests miss (mc_enable asserted both times).
  - Stimulus: drop rdy for 3 cycles during MISS.
  - Required response: mc_enable, state and outputs hold; completion resumes after rdy=1.
- Async reset mid-MISS: mc_enable falls without a clock edge; a prior hit line now misses.
